// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and helpers for the FFT frame buffer
//
// Purpose: default sizes, the sample type and the bit-reversal helper
//          used when frames are loaded in bit-reversed order.
// Ports:   none (package).
package fft_pkg;

  localparam int DEFAULT_BITS   = 16;
  localparam int DEFAULT_POINTS = 32;
  localparam int LOG2_POINTS    = $clog2(DEFAULT_POINTS);

  // One complex sample, {re, im}.
  typedef logic [2*DEFAULT_BITS-1:0] sample_t;

  // Reverses the nbits least-significant bits of idx; higher bits return 0.
  function automatic logic [31:0] bitrev(input logic [31:0] idx, input int nbits);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        r[5'(i)] = idx[5'(nbits - 1 - i)];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_frame_bank.sv
// rtl/fft_frame_bank.sv - one POINTS-entry sample register bank
//
// Purpose: holds one frame of complex samples and presents it in parallel.
// Ports:   clk, reset (async, active-high) -- clock and reset
//          we, idx, wdata                  -- single-entry write port
//          data                            -- flat frame, entry i at [i*2*bits +: 2*bits]
module fft_frame_bank
  import fft_pkg::*;
#(
  parameter int bits   = DEFAULT_BITS,
  parameter int POINTS = DEFAULT_POINTS,
  localparam int LW    = $clog2(POINTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [LW-1:0]            idx,
  input  logic [2*bits-1:0]        wdata,
  output logic [POINTS*2*bits-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (we) begin
      data[idx*2*bits +: 2*bits] <= wdata;
    end
  end

endmodule

// File: rtl/fft_frame_buffer.sv
// rtl/fft_frame_buffer.sv - ping-pong serial-to-parallel frame buffer for the FFT
//
// Purpose: collects POINTS samples per frame (optionally bit-reversed) into one
//          of two banks and presents completed frames in parallel.
// Ports:   clk, reset (async, active-high)
//          in_valid/in_ready/in_data/in_last -- serial sample input
//          out_valid/out_ready/out_data      -- parallel frame output
//          frame_err                         -- one-cycle framing-violation pulse
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int bits    = DEFAULT_BITS,
  parameter int POINTS  = DEFAULT_POINTS,
  parameter int BIT_REV = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2*bits-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [POINTS*2*bits-1:0] out_data,
  output logic                     frame_err
);

  localparam int LW = $clog2(POINTS);
  localparam logic [LW-1:0] LAST_IDX = LW'(POINTS - 1);

  logic [1:0]                     full;
  logic [1:0]                     full_next;
  logic                           wr_bank;
  logic                           rd_bank;
  logic [LW-1:0]                  wr_cnt;
  logic [LW-1:0]                  wr_idx;
  logic                           in_acc;
  logic                           out_acc;
  logic                           at_end;
  logic [POINTS*2*bits-1:0]       bank0_data;
  logic [POINTS*2*bits-1:0]       bank1_data;

  // Handshake outputs depend on registers only.
  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_data  = rd_bank ? bank1_data : bank0_data;

  assign in_acc  = in_valid && in_ready;
  assign out_acc = out_valid && out_ready;
  assign at_end  = (wr_cnt == LAST_IDX);

  always_comb begin
    wr_idx = wr_cnt;
    if (BIT_REV != 0) begin
      wr_idx = LW'(bitrev(32'(wr_cnt), LW));
    end
  end

  // A completing write targets a bank whose full flag is clear, while an output
  // accept targets a bank whose flag is set, so the two never collide.
  always_comb begin
    full_next = full;
    if (in_acc && at_end) begin
      full_next[wr_bank] = 1'b1;
    end
    if (out_acc) begin
      full_next[rd_bank] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full      <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      full      <= full_next;
      frame_err <= 1'b0;
      if (out_acc) begin
        rd_bank <= ~rd_bank;
      end
      if (in_acc) begin
        if (at_end) begin
          wr_bank   <= ~wr_bank;
          wr_cnt    <= '0;
          frame_err <= !in_last;
        end else if (in_last) begin
          // Early last: drop the partial frame and restart in the same bank.
          wr_cnt    <= '0;
          frame_err <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + LW'(1);
        end
      end
    end
  end

  fft_frame_bank #(
    .bits   (bits),
    .POINTS (POINTS)
  ) u_bank0 (
    .clk   (clk),
    .reset (reset),
    .we    (in_acc && !wr_bank),
    .idx   (wr_idx),
    .wdata (in_data),
    .data  (bank0_data)
  );

  fft_frame_bank #(
    .bits   (bits),
    .POINTS (POINTS)
  ) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .we    (in_acc && wr_bank),
    .idx   (wr_idx),
    .wdata (in_data),
    .data  (bank1_data)
  );

endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb/tb_fft_frame_buffer.sv - self-checking bench for fft_frame_buffer
module tb_fft_frame_buffer;

  localparam int B  = 8;
  localparam int W  = 2 * B;
  localparam int P  = 32;
  localparam int RP = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready, in_last, out_valid, out_ready, frame_err;
  logic [W-1:0]     in_data;
  logic [P*W-1:0]   out_data;

  logic             r_in_valid, r_in_ready, r_in_last, r_out_valid, r_out_ready, r_frame_err;
  logic [W-1:0]     r_in_data;
  logic [RP*W-1:0]  r_out_data;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: queue of presented frames plus the frame being assembled.
  logic [P*W-1:0] fq[$];
  logic [P*W-1:0] part;
  logic [P*W-1:0] dummy;
  int             cnt;
  logic           m_err;

  always #5 clk = ~clk;

  fft_frame_buffer #(.bits(B), .POINTS(P), .BIT_REV(0)) u_nat (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .frame_err(frame_err)
  );

  fft_frame_buffer #(.bits(B), .POINTS(RP), .BIT_REV(1)) u_rev (
    .clk(clk), .reset(reset),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data), .in_last(r_in_last),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .frame_err(r_frame_err)
  );

  task automatic check(input string tag, input logic [P*W-1:0] got, input logic [P*W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    fq.delete();
    part  = '0;
    cnt   = 0;
    m_err = 1'b0;
  endtask

  task automatic check_outputs();
    check("in_ready", in_ready, fq.size() < 2);
    check("out_valid", out_valid, fq.size() > 0);
    check("frame_err", frame_err, m_err);
    if (fq.size() > 0) check("out_data", out_data, fq[0]);
    check("rev_frame_err", r_frame_err, 0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at the negedge.
  task automatic step(input logic iv, input logic il, input logic [W-1:0] d,
                      input logic ordy, output logic acc);
    logic oacc;
    in_valid = iv; in_last = il; in_data = d; out_ready = ordy;
    acc  = iv && (fq.size() < 2);
    oacc = ordy && (fq.size() > 0);
    @(posedge clk);
    m_err = 1'b0;
    if (oacc) dummy = fq.pop_front();
    if (acc) begin
      part[cnt*W +: W] = d;
      if (cnt == P - 1) begin
        fq.push_back(part);
        cnt   = 0;
        m_err = !il;
      end else if (il) begin
        cnt   = 0;
        m_err = 1'b1;
      end else begin
        cnt++;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [W-1:0] d, input logic il, input logic ordy);
    logic a;
    a = 1'b0;
    for (int t = 0; t < 200 && !a; t++) step(1'b1, il, d, ordy, a);
    if (!a) check("send_timeout", a, 1);
  endtask

  task automatic send_frame(input int last_at, input logic ordy);
    for (int k = 0; k < P; k++) send(W'($urandom), k == last_at, ordy);
  endtask

  task automatic idle(input int n, input logic ordy);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, ordy, a);
  endtask

  initial begin
    logic a;
    logic [P*W-1:0] expv;
    int ord[RP];
    ord = '{0, 4, 2, 6, 1, 5, 3, 7};

    reset = 1'b1;
    in_valid = 0; in_last = 0; in_data = '0; out_ready = 0;
    r_in_valid = 0; r_in_last = 0; r_in_data = '0; r_out_ready = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_out_data", out_data, 0);
    check_outputs();

    // Bit-reversed 8-point frame on the second instance.
    for (int k = 0; k < RP; k++) begin
      r_in_valid = 1'b1; r_in_data = {8'(k), 8'(k)}; r_in_last = (k == RP - 1);
      if (k == RP - 1) check("rev_valid_early", r_out_valid, 0);
      step(1'b0, 1'b0, '0, 1'b0, a);
    end
    r_in_valid = 1'b0; r_in_last = 1'b0;
    check("rev_valid", r_out_valid, 1);
    expv = '0;
    for (int i = 0; i < RP; i++) expv[i*W +: W] = {8'(ord[i]), 8'(ord[i])};
    check("rev_data", r_out_data, expv);
    check("rev_ready", r_in_ready, 1);

    // Natural-order frame, k -> {k, -k}.
    for (int k = 0; k < P; k++) send({8'(k), 8'(-k)}, k == P - 1, 1'b1);
    expv = '0;
    for (int i = 0; i < P; i++) expv[i*W +: W] = {8'(i), 8'(-i)};
    check("nat_data", out_data, expv);
    check("nat_valid", out_valid, 1);
    idle(2, 1'b1);

    // Backpressure: two frames fill both banks, third frame's first sample waits.
    send_frame(P - 1, 1'b0);
    send_frame(P - 1, 1'b0);
    check("bp_ready_low", in_ready, 0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 16'h5a5a, 1'b0, a);
    step(1'b1, 1'b0, 16'h5a5a, 1'b1, a);
    check("bp_ready_back", in_ready, 1);
    send_frame(P - 1, 1'b0);
    idle(6, 1'b1);

    // Early last on sample 5, then a clean frame; then a frame missing in_last.
    for (int k = 0; k < 6; k++) send(W'($urandom), k == 5, 1'b1);
    check("early_err", frame_err, 1);
    send_frame(P - 1, 1'b1);
    idle(2, 1'b1);
    send_frame(-1, 1'b1);
    check("miss_err", frame_err, 1);
    idle(2, 1'b1);

    // Completion coinciding with an output accept, one bank already full.
    send_frame(P - 1, 1'b0);
    for (int k = 0; k < P - 1; k++) send(W'($urandom), 1'b0, 1'b0);
    send(W'($urandom), 1'b1, 1'b1);
    check("simul_valid", out_valid, 1);
    idle(3, 1'b1);

    // Randomized traffic with varying consumer behaviour and occasional framing errors.
    for (int blk = 0; blk < 6; blk++) begin
      for (int i = 0; i < 400; i++) begin
        logic il;
        il = (cnt == P - 1) ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 79) == 0);
        step($urandom_range(0, 3) != 0, il, W'($urandom),
             $urandom_range(0, blk) == 0, a);
      end
    end
    idle(4, 1'b1);

    // Asynchronous reset mid-frame with one full bank.
    send_frame(P - 1, 1'b0);
    for (int k = 0; k < 10; k++) send(W'($urandom), 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_data", out_data, 0);
    check("arst_ready", in_ready, 1);
    check("arst_err", frame_err, 0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    send_frame(P - 1, 1'b0);
    check("post_rst_valid", out_valid, 1);
    idle(3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_buffer.md
# fft_frame_buffer

Parametrised, double-buffered frame register for the FFT datapath. It accepts complex samples serially through a valid/ready handshake and optionally stores them in bit-reversed order. Once a full frame of `POINTS` samples is collected, it presents the frame in parallel to the butterfly stages through a second valid/ready handshake. A ping-pong bank pair lets the next frame load while the current frame is held for the consumer.

## Interface
- `bits`, default 16: width of each real/imag component; a sample is `2*bits` wide, {re, im}.
- `POINTS`, default 32: samples per frame; must be a power of two, ≥ 2.
- `BIT_REV`, default 1: 1 means sample k is stored at index bitrev(k); 0 means natural order.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `reset`, input, 1: reset, active-high, asynchronous. One clock; reset is asynchronous and active-high.
- `in_valid`, input, 1: input sample valid.
- `in_ready`, output, 1: buffer can accept a sample.
- `in_data`, input, 2*bits: input sample {re, im}.
- `in_last`, input, 1: marks the final sample of a frame.
- `out_valid`, output, 1: a complete frame is presented.
- `out_ready`, input, 1: consumer accepts the frame.
- `out_data`, output, POINTS*2*bits: frame contents; index i occupies bits [i*2*bits +: 2*bits].
- `frame_err`, output, 1: one-cycle pulse flagging a framing violation.

## Operation
- **State:**
  - two banks, bank0 and bank1, each holding POINTS samples;
  - `full[1:0]`;
  - `wr_bank`, `rd_bank` (1 bit each);
  - `wr_cnt`, log2(POINTS) bits.
- **Reset:**
  - all bank entries, `full`, `wr_bank`, `rd_bank` and `wr_cnt` go to 0;
  - so `out_valid`=0, `out_data`=0, `frame_err`=0, `in_ready`=1.
- **Input accept:** `in_valid && in_ready`.
  - The sample is written to `bank[wr_bank]` at index bitrev(`wr_cnt`) if `BIT_REV`, else at `wr_cnt`.
  - `wr_cnt` increments.
- **Frame completion:** an accept with `wr_cnt == POINTS-1`.
  - Sets `full[wr_bank]`, toggles `wr_bank`, and wraps `wr_cnt` to 0.
  - If `in_last`=0 on that sample, the frame still completes and `frame_err` pulses.
- **Early last:** an accept with `in_last`=1 and `wr_cnt < POINTS-1`.
  - The sample is written, `wr_cnt` returns to 0, and `full` and `wr_bank` are unchanged, so the partial frame is discarded.
  - `frame_err` pulses.
- **Signal derivation:**
  - `in_ready` = !`full[wr_bank]`.
  - `out_valid` = `full[rd_bank]`.
  - `out_data` = `bank[rd_bank]`.
  - All three are combinational from registers only; there is no combinational path from `in_valid` or `out_ready`.
- **Output accept:** `out_valid && out_ready` clears `full[rd_bank]` and toggles `rd_bank`. Bank contents are not cleared.
- **Simultaneous events:** a frame completion and an output accept in the same cycle act on different banks, and both take effect.
- **Backpressure:** with both banks full, `in_ready`=0. `in_valid` is ignored, and no counter or bank changes.
- **Width rules:** data is stored verbatim, with no scaling or rounding. bitrev reverses the log2(POINTS) LSBs.

## Timing
- **Latency:** from the accept of the last sample of a frame to `out_valid`=1 is 1 cycle, visible after that edge.
- **Throughput:** 1 sample per cycle sustained while the consumer accepts each frame within POINTS cycles of it being presented.
- **Input freeze:** after the 2nd unconsumed frame completes, `in_ready` drops at the next edge. It rises the cycle after an output accept.
- **`frame_err`:** asserted for exactly the cycle following the offending accept.
- **Reset mid-frame:** asynchronous; it discards any partial and full frames immediately, and outputs take their reset values without waiting for a clock edge.
- **Frame hold:** `out_data` is stable while `out_valid`=1 and `out_ready`=0.

## Structure
- **Shared package `fft_pkg`:**
  - `sample_t` width `2*bits`;
  - function `bitrev(idx, nbits)`;
  - localparam `LOG2_POINTS` = $clog2(POINTS).
- **Sub-module `fft_frame_bank`:**
  - one POINTS×2*bits register bank with write-enable, index and data inputs, asynchronous reset to 0, and a flat parallel output;
  - instantiated twice.
  - Control (counters, `full` flags, bank selects, error detection) stays in `fft_frame_buffer`.

## Test plan
- **Natural-order frame:** POINTS=32, BIT_REV=0, `out_ready`=1. Send samples k → {k, −k} for k=0..31 with `in_last` on k=31.
  - `out_valid`=1 exactly one cycle after k=31 is accepted.
  - `out_data` index i = {i, −i}.
  - `frame_err` never asserts.
- **Bit-reversed frame:** POINTS=8, BIT_REV=1. Send samples 0..7.
  - `out_data` index order reads 0, 4, 2, 6, 1, 5, 3, 7.
- **Backpressure:** `out_ready`=0; stream 3 frames back-to-back.
  - `in_ready` falls after the 64th accept.
  - The 3rd frame's first sample is held off.
  - Raising `out_ready` for one cycle presents frame 2 next cycle and restores `in_ready`=1.
- **Framing errors:**
  - `in_last` on sample 5 of a 32-point frame: `frame_err` pulses, and the following 32 samples form the next presented frame.
  - `in_last` missing on sample 31: the frame is presented, and `frame_err` pulses once.
- **Simultaneous completion and output accept:** a frame completes in the same cycle as an output accept, with 1 frame already full.
  - Both `full` flags update correctly.
  - `out_valid` stays 1, and the new frame's data appears.
- **Reset mid-operation:** assert `reset` asynchronously mid-frame with 1 full bank.
  - `out_valid`=0, `out_data`=0, `in_ready`=1 immediately.
  - The next 32 samples produce a clean frame.
